// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative EX-stage shift unit:
// op encodings, FSM state type and datapath width.
package mips_shift_pkg;

    localparam int XLEN = 32;
    localparam int AMT_W = 5;

    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle between the EX-stage control and the shift unit.
interface iter_shifter_if;
    import mips_shift_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-bit shift step (SLL/SRL/SRA), pass-through otherwise.
module shift_step
    import mips_shift_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout
);

    // Select the one-position shift for the captured op
    always_comb begin
        dout = din;
        case (op)
            SH_SLL:  dout = {din[XLEN-2:0], 1'b0};
            SH_SRL:  dout = {1'b0, din[XLEN-1:1]};
            SH_SRA:  dout = {din[XLEN-1], din[XLEN-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: one bit position per clock, stalls the pipeline via busy.
module iter_shifter
    import mips_shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    iter_shifter_if.slave bus
);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_r_q, op_r_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               done_q, done_d;
    logic [XLEN-1:0]    step_out;
    logic               unused_amt_hi;

    // Upper amount bits are ignored: shift amount is modulo 32
    assign unused_amt_hi = ^bus.operand_b[XLEN-1:AMT_W];

    shift_step u_step (
        .op   (op_r_q),
        .din  (work_q),
        .dout (step_out)
    );

    // Next-state and datapath updates; flush overrides every state
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_r_d   = op_r_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        work_d = bus.operand_a;
                        cnt_d  = bus.operand_b[AMT_W-1:0];
                        op_r_d = bus.op;
                        if ((bus.operand_b[AMT_W-1:0] != '0) && (bus.op != SH_PASS))
                            state_d = SHIFT;
                        else
                            state_d = DONE;
                    end
                end
                SHIFT: begin
                    work_d = step_out;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1)
                        state_d = DONE;
                end
                DONE: begin
                    result_d = work_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_r_q   <= SH_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_r_q   <= op_r_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
